ctrl_branch_unit: RTL and testbench

EX-stage branch resolution unit for the 8-bit RISC core. It is the producer side of the program-counter redirect interface: it drives branch_taken_EX and nxt_prog_ctr_EX into the program counter.
- Tracks the PC of each instruction through IF→ID→EX.
- Evaluates conditional branches against the EX flags.
- Keeps a small hardware return-address stack (RAS) for CALL/RET.
- Squashes the wrong-path instructions fetched after a taken branch.

---
 rtl/ctrl_branch_unit.sv | 161 ++++++++++++++++
 tb/tb_ctrl_branch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_branch_unit.sv
// EX-stage branch resolution, PC tracking, wrong-path squash and return stack.
// Optional macro BRANCH_RAS_EN builds the CALL/RET return-address stack.
module ctrl_branch_unit #(
  parameter int PROG_CTR_WID = 10,
  parameter int RAS_DEPTH    = 4,
  parameter int SHADOW       = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PROG_CTR_WID-1:0]       prog_ctr,
  input  logic [2:0]                    br_op_EX,
  input  logic [PROG_CTR_WID-1:0]       br_addr_EX,
  input  logic                          zero_flag_EX,
  input  logic                          carry_flag_EX,
  output logic                          branch_taken_EX,
  output logic [PROG_CTR_WID-1:0]       nxt_prog_ctr_EX,
  output logic                          flush_pipe,
  output logic [PROG_CTR_WID-1:0]       pc_EX,
  output logic                          ras_ovf,
  output logic                          ras_unf,
  output logic [$clog2(RAS_DEPTH):0]    ras_cnt
);

  localparam int W  = PROG_CTR_WID;
  localparam int CW = $clog2(RAS_DEPTH) + 1;
  localparam int SW = (SHADOW < 4) ? 2 : $clog2(SHADOW + 1);

  logic [W-1:0]  pc_ID;
  logic [W-1:0]  pc_inc;
  logic [SW-1:0] shadow_cnt;
  logic          active;
  logic          take;
  logic [W-1:0]  target;
  logic [7:0]    op_oh;

  assign pc_inc = pc_EX + W'(1);
  assign active = !reset && (shadow_cnt == '0);
  assign op_oh  = 8'b1 << br_op_EX;

`ifdef BRANCH_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [W-1:0]  ras_mem [RAS_DEPTH];
  logic [PW-1:0] sp;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          unf_q;
  logic          do_push;
  logic          do_pop;
  logic          set_unf;
  logic [W-1:0]  ras_top;
  logic          ras_full;

  assign ras_top  = ras_mem[sp - PW'(1)];
  assign ras_full = (cnt_q == CW'(RAS_DEPTH));
`endif

  always_comb begin
    take   = 1'b0;
    target = br_addr_EX;
`ifdef BRANCH_RAS_EN
    do_push = 1'b0;
    do_pop  = 1'b0;
    set_unf = 1'b0;
`endif
    unique case (1'b1)
      op_oh[0]: take = 1'b0;
      op_oh[1]: take = 1'b1;
      op_oh[2]: take = zero_flag_EX;
      op_oh[3]: take = !zero_flag_EX;
      op_oh[4]: take = carry_flag_EX;
      op_oh[5]: take = !carry_flag_EX;
`ifdef BRANCH_RAS_EN
      op_oh[6]: begin
        take    = 1'b1;
        do_push = 1'b1;
      end
      op_oh[7]: begin
        if (cnt_q != '0) begin
          take   = 1'b1;
          target = ras_top;
          do_pop = 1'b1;
        end else begin
          set_unf = 1'b1;
        end
      end
`else
      op_oh[6]: take = 1'b1;
      op_oh[7]: take = 1'b0;
`endif
      default: take = 1'b0;
    endcase
    // Wrong-path slots and reset cycles must have no side effects.
    if (!active) begin
      take = 1'b0;
`ifdef BRANCH_RAS_EN
      do_push = 1'b0;
      do_pop  = 1'b0;
      set_unf = 1'b0;
`endif
    end
  end

  assign branch_taken_EX = take;
  assign nxt_prog_ctr_EX = reset ? '0 : (take ? target : pc_inc);
  assign flush_pipe      = !reset && (shadow_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_ID      <= '0;
      pc_EX      <= '0;
      shadow_cnt <= '0;
    end else begin
      pc_ID <= prog_ctr;
      pc_EX <= pc_ID;
      if (take)
        shadow_cnt <= SW'(SHADOW);
      else if (shadow_cnt != '0)
        shadow_cnt <= shadow_cnt - SW'(1);
    end
  end

`ifdef BRANCH_RAS_EN
  always_ff @(posedge clk) begin
    if (do_push)
      ras_mem[sp] <= pc_inc;
  end

  // Full-stack push wraps the pointer onto the oldest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp    <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (do_push) begin
        sp <= sp + PW'(1);
        if (ras_full)
          ovf_q <= 1'b1;
        else
          cnt_q <= cnt_q + CW'(1);
      end else if (do_pop) begin
        sp    <= sp - PW'(1);
        cnt_q <= cnt_q - CW'(1);
      end
      if (set_unf)
        unf_q <= 1'b1;
    end
  end

  assign ras_cnt = cnt_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
`else
  assign ras_cnt = '0;
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_branch_unit.sv
// Directed bench for ctrl_branch_unit; checks both RAS build options.
module tb_ctrl_branch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] prog_ctr;
  logic [2:0] br_op_EX;
  logic [9:0] br_addr_EX;
  logic       zero_flag_EX;
  logic       carry_flag_EX;
  logic       branch_taken_EX;
  logic [9:0] nxt_prog_ctr_EX;
  logic       flush_pipe;
  logic [9:0] pc_EX;
  logic       ras_ovf;
  logic       ras_unf;
  logic [2:0] ras_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ctrl_branch_unit dut (
    .clk(clk),
    .reset(reset),
    .prog_ctr(prog_ctr),
    .br_op_EX(br_op_EX),
    .br_addr_EX(br_addr_EX),
    .zero_flag_EX(zero_flag_EX),
    .carry_flag_EX(carry_flag_EX),
    .branch_taken_EX(branch_taken_EX),
    .nxt_prog_ctr_EX(nxt_prog_ctr_EX),
    .flush_pipe(flush_pipe),
    .pc_EX(pc_EX),
    .ras_ovf(ras_ovf),
    .ras_unf(ras_unf),
    .ras_cnt(ras_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Commit current EX op, then park pc_EX at pc with any shadow expired.
  task automatic at_pc(input logic [9:0] pc);
    tick();
    br_op_EX = 3'd0;
    prog_ctr = pc;
    tick();
    tick();
  endtask

  task automatic present(input logic [2:0] op, input logic [9:0] addr);
    br_op_EX   = op;
    br_addr_EX = addr;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    prog_ctr = 10'h2AA;
    br_op_EX = 3'd1;
    br_addr_EX = 10'h155;
    zero_flag_EX = 1'b0;
    carry_flag_EX = 1'b0;
    tick(); tick(); tick();
    tests++; if (branch_taken_EX !== 1'b0) begin fails++;
      $display("FAIL reset_taken got %b want 0", branch_taken_EX); end
    tests++; if (flush_pipe !== 1'b0) begin fails++;
      $display("FAIL reset_flush got %b want 0", flush_pipe); end
    tests++; if (pc_EX !== 10'h000) begin fails++;
      $display("FAIL reset_pc_EX got %h want 000", pc_EX); end
    tests++; if (nxt_prog_ctr_EX !== 10'h000) begin fails++;
      $display("FAIL reset_nxt got %h want 000", nxt_prog_ctr_EX); end
    tests++; if (ras_cnt !== 3'd0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
      fails++; $display("FAIL reset_ras got cnt=%0d ovf=%b unf=%b want 0 0 0",
        ras_cnt, ras_ovf, ras_unf); end
    br_op_EX = 3'd0;
    reset = 1'b0;
  endtask

  task automatic test_jmp();
    at_pc(10'h010);
    present(3'd1, 10'h155);
    tests++; if (branch_taken_EX !== 1'b1 || nxt_prog_ctr_EX !== 10'h155) begin
      fails++; $display("FAIL jmp_taken got %b/%h want 1/155",
        branch_taken_EX, nxt_prog_ctr_EX); end
    tests++; if (flush_pipe !== 1'b0) begin fails++;
      $display("FAIL jmp_noflush got %b want 0", flush_pipe); end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (flush_pipe !== 1'b1 || branch_taken_EX !== 1'b0) begin
        fails++; $display("FAIL jmp_shadow%0d got flush=%b taken=%b want 1 0",
          i, flush_pipe, branch_taken_EX); end
    end
    tick();
    br_op_EX = 3'd0;
    #1;
    tests++; if (flush_pipe !== 1'b0) begin fails++;
      $display("FAIL jmp_shadow_end got %b want 0", flush_pipe); end
  endtask

  task automatic test_conditionals();
    at_pc(10'h030);
    zero_flag_EX = 1'b0;
    present(3'd2, 10'h111);
    tests++; if (branch_taken_EX !== 1'b0 || nxt_prog_ctr_EX !== 10'h031) begin
      fails++; $display("FAIL jz_z0 got %b/%h want 0/031",
        branch_taken_EX, nxt_prog_ctr_EX); end
    tick();
    tests++; if (flush_pipe !== 1'b0) begin fails++;
      $display("FAIL jz_noflush got %b want 0", flush_pipe); end
    at_pc(10'h040);
    carry_flag_EX = 1'b0;
    present(3'd5, 10'h0A0);
    tests++; if (branch_taken_EX !== 1'b1 || nxt_prog_ctr_EX !== 10'h0A0) begin
      fails++; $display("FAIL jnc_c0 got %b/%h want 1/0a0",
        branch_taken_EX, nxt_prog_ctr_EX); end
    at_pc(10'h050);
    carry_flag_EX = 1'b1;
    present(3'd4, 10'h123);
    tests++; if (branch_taken_EX !== 1'b1 || nxt_prog_ctr_EX !== 10'h123) begin
      fails++; $display("FAIL jc_c1 got %b/%h want 1/123",
        branch_taken_EX, nxt_prog_ctr_EX); end
    at_pc(10'h058);
    carry_flag_EX = 1'b0;
    present(3'd4, 10'h124);
    tests++; if (branch_taken_EX !== 1'b0 || nxt_prog_ctr_EX !== 10'h059) begin
      fails++; $display("FAIL jc_c0 got %b/%h want 0/059",
        branch_taken_EX, nxt_prog_ctr_EX); end
    at_pc(10'h060);
    zero_flag_EX = 1'b1;
    present(3'd3, 10'h222);
    tests++; if (branch_taken_EX !== 1'b0) begin fails++;
      $display("FAIL jnz_z1 got %b want 0", branch_taken_EX); end
    present(3'd2, 10'h222);
    tests++; if (branch_taken_EX !== 1'b1 || nxt_prog_ctr_EX !== 10'h222) begin
      fails++; $display("FAIL jz_z1 got %b/%h want 1/222",
        branch_taken_EX, nxt_prog_ctr_EX); end
    at_pc(10'h3FF);
    present(3'd0, 10'h222);
    tests++; if (branch_taken_EX !== 1'b0 || nxt_prog_ctr_EX !== 10'h000) begin
      fails++; $display("FAIL pc_wrap got %b/%h want 0/000",
        branch_taken_EX, nxt_prog_ctr_EX); end
  endtask

`ifdef BRANCH_RAS_EN
  task automatic test_call_ret();
    at_pc(10'h020);
    present(3'd6, 10'h200);
    tests++; if (branch_taken_EX !== 1'b1 || nxt_prog_ctr_EX !== 10'h200) begin
      fails++; $display("FAIL call got %b/%h want 1/200",
        branch_taken_EX, nxt_prog_ctr_EX); end
    at_pc(10'h070);
    tests++; if (ras_cnt !== 3'd1) begin fails++;
      $display("FAIL call_cnt got %0d want 1", ras_cnt); end
    present(3'd7, 10'h000);
    tests++; if (branch_taken_EX !== 1'b1 || nxt_prog_ctr_EX !== 10'h021) begin
      fails++; $display("FAIL ret got %b/%h want 1/021",
        branch_taken_EX, nxt_prog_ctr_EX); end
    at_pc(10'h078);
    tests++; if (ras_cnt !== 3'd0) begin fails++;
      $display("FAIL ret_cnt got %0d want 0", ras_cnt); end
  endtask

  task automatic test_stack_limits();
    logic [9:0] exp;
    for (int i = 0; i < 5; i++) begin
      at_pc(10'h100 + 10'(i));
      present(3'd6, 10'h300);
    end
    at_pc(10'h080);
    tests++; if (ras_cnt !== 3'd4 || ras_ovf !== 1'b1) begin fails++;
      $display("FAIL ovf got cnt=%0d ovf=%b want 4 1", ras_cnt, ras_ovf); end
    for (int i = 0; i < 4; i++) begin
      exp = 10'h105 - 10'(i);
      present(3'd7, 10'h000);
      tests++; if (branch_taken_EX !== 1'b1 || nxt_prog_ctr_EX !== exp) begin
        fails++; $display("FAIL ret%0d got %b/%h want 1/%h",
          i, branch_taken_EX, nxt_prog_ctr_EX, exp); end
      at_pc(10'h090);
    end
    present(3'd7, 10'h000);
    tests++; if (branch_taken_EX !== 1'b0 || nxt_prog_ctr_EX !== 10'h091) begin
      fails++; $display("FAIL ret_empty got %b/%h want 0/091",
        branch_taken_EX, nxt_prog_ctr_EX); end
    tick();
    tests++; if (ras_unf !== 1'b1 || ras_cnt !== 3'd0 || flush_pipe !== 1'b0) begin
      fails++; $display("FAIL unf got unf=%b cnt=%0d flush=%b want 1 0 0",
        ras_unf, ras_cnt, flush_pipe); end
  endtask

  task automatic test_wrap_reset();
    at_pc(10'h3FF);
    present(3'd6, 10'h010);
    at_pc(10'h0B0);
    present(3'd7, 10'h000);
    tests++; if (branch_taken_EX !== 1'b1 || nxt_prog_ctr_EX !== 10'h000) begin
      fails++; $display("FAIL ret_wrap got %b/%h want 1/000",
        branch_taken_EX, nxt_prog_ctr_EX); end
    at_pc(10'h0C0);
    present(3'd6, 10'h001);
    tick();
    tests++; if (flush_pipe !== 1'b1 || ras_cnt !== 3'd1) begin fails++;
      $display("FAIL pre_reset got flush=%b cnt=%0d want 1 1",
        flush_pipe, ras_cnt); end
    reset = 1'b1;
    br_op_EX = 3'd0;
    tick();
    tests++; if (flush_pipe !== 1'b0 || ras_cnt !== 3'd0 || pc_EX !== 10'h000) begin
      fails++; $display("FAIL mid_reset got flush=%b cnt=%0d pc=%h want 0 0 000",
        flush_pipe, ras_cnt, pc_EX); end
    tests++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin fails++;
      $display("FAIL mid_reset_flags got %b %b want 0 0", ras_ovf, ras_unf); end
    reset = 1'b0;
    tick();
    tests++; if (flush_pipe !== 1'b0) begin fails++;
      $display("FAIL post_reset_flush got %b want 0", flush_pipe); end
  endtask
`else
  task automatic test_ras_disabled();
    at_pc(10'h020);
    present(3'd6, 10'h200);
    tests++; if (branch_taken_EX !== 1'b1 || nxt_prog_ctr_EX !== 10'h200) begin
      fails++; $display("FAIL call_as_jmp got %b/%h want 1/200",
        branch_taken_EX, nxt_prog_ctr_EX); end
    at_pc(10'h070);
    tests++; if (ras_cnt !== 3'd0) begin fails++;
      $display("FAIL call_cnt got %0d want 0", ras_cnt); end
    present(3'd7, 10'h155);
    tests++; if (branch_taken_EX !== 1'b0 || nxt_prog_ctr_EX !== 10'h071) begin
      fails++; $display("FAIL ret_none got %b/%h want 0/071",
        branch_taken_EX, nxt_prog_ctr_EX); end
    tick();
    tests++; if (ras_unf !== 1'b0 || ras_ovf !== 1'b0 || flush_pipe !== 1'b0) begin
      fails++; $display("FAIL ret_flags got unf=%b ovf=%b flush=%b want 0 0 0",
        ras_unf, ras_ovf, flush_pipe); end
    at_pc(10'h0C0);
    present(3'd1, 10'h001);
    tick();
    tests++; if (flush_pipe !== 1'b1) begin fails++;
      $display("FAIL pre_reset got flush=%b want 1", flush_pipe); end
    reset = 1'b1;
    br_op_EX = 3'd0;
    tick();
    tests++; if (flush_pipe !== 1'b0 || pc_EX !== 10'h000) begin fails++;
      $display("FAIL mid_reset got flush=%b pc=%h want 0 000",
        flush_pipe, pc_EX); end
    reset = 1'b0;
    tick();
    tests++; if (flush_pipe !== 1'b0) begin fails++;
      $display("FAIL post_reset_flush got %b want 0", flush_pipe); end
  endtask
`endif

  initial begin
    test_reset();
    test_jmp();
    test_conditionals();
`ifdef BRANCH_RAS_EN
    test_call_ret();
    test_stack_limits();
    test_wrap_reset();
`else
    test_ras_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
